// File: rtl/reg_file_sb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : reg_file_sb                                                   |
// | Purpose  : Integer register file with NRP combinational read ports, one  |
// |            write port and a busy-bit scoreboard. Issue marks a          |
// |            destination pending; writeback stores data and clears the    |
// |            mark. Register 0 reads zero and is never pending.            |
// | Ports    : clk, res_n            clock / async active-low reset         |
// |            rs_addr/rs_data/rs_busy  packed read ports (NRP of them)     |
// |            wr_en/wr_addr/wr_data    writeback port                      |
// |            issue_valid/issue_rd/issue_ready  issue handshake            |
// |            flush                 synchronous clear of all pending marks |
// |            pend_cnt              registered count of pending registers  |
// | Options  : RF_BYPASS_EN - same-cycle write-to-read forwarding           |
// | Revision : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module reg_file_sb #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NRP   = 2,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic                       clk,
   input  logic                       res_n,
   input  logic [NRP*AW-1:0]          rs_addr,
   output logic [NRP*XLEN-1:0]        rs_data,
   output logic [NRP-1:0]             rs_busy,
   input  logic                       wr_en,
   input  logic [AW-1:0]              wr_addr,
   input  logic [XLEN-1:0]            wr_data,
   input  logic                       issue_valid,
   input  logic [AW-1:0]              issue_rd,
   output logic                       issue_ready,
   input  logic                       flush,
   output logic [$clog2(NREGS+1)-1:0] pend_cnt
);

   localparam int CW = $clog2(NREGS+1);

   logic [XLEN-1:0]  mem [NREGS];
   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_nxt;
   logic [CW-1:0]    cnt_nxt;
   logic             wr_act;
   logic             issue_act;

   assign wr_act = wr_en && (wr_addr != '0);

   // A same-cycle write to the requested register frees it, so the new
   // writer may be accepted even though the bit is still set.
   assign issue_ready = !busy[issue_rd] || (wr_en && (wr_addr == issue_rd)) ||
                        (issue_rd == '0);
   assign issue_act   = issue_valid && issue_ready && (issue_rd != '0);

   // Clear from writeback first, then set from issue so that a same-register
   // collision leaves the bit set; flush overrides both.
   always_comb begin
      busy_nxt = busy;
      if (wr_act)
         busy_nxt[wr_addr] = 1'b0;
      if (issue_act)
         busy_nxt[issue_rd] = 1'b1;
      if (flush)
         busy_nxt = '0;
      busy_nxt[0] = 1'b0;
   end

   // Count is taken from the next-state vector so it is exact in the same
   // cycle the busy vector updates.
   always_comb begin
      cnt_nxt = '0;
      for (int i = 0; i < NREGS; i++)
         cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         busy     <= '0;
         pend_cnt <= '0;
      end else begin
         busy     <= busy_nxt;
         pend_cnt <= cnt_nxt;
      end
   end

   // Entry 0 is cleared by reset and never written.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         for (int i = 0; i < NREGS; i++)
            mem[i] <= '0;
      end else if (wr_act) begin
         mem[wr_addr] <= wr_data;
      end
   end

   for (genvar p = 0; p < NRP; p++) begin : g_rp
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] stored;

      assign addr   = rs_addr[p*AW +: AW];
      assign stored = (addr == '0) ? '0 : mem[addr];

`ifdef RF_BYPASS_EN
      logic byp;
      assign byp = wr_act && (wr_addr == addr);
      assign rs_data[p*XLEN +: XLEN] = byp ? wr_data : stored;
      assign rs_busy[p]              = busy[addr] && !byp;
`else
      assign rs_data[p*XLEN +: XLEN] = stored;
      assign rs_busy[p]              = busy[addr];
`endif
   end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_reg_file_sb                                                |
// | Purpose  : Directed self-checking bench for reg_file_sb (default params). |
// |            Expectations for same-cycle forwarding follow RF_BYPASS_EN.  |
// | Revision : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module tb_reg_file_sb;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRP   = 2;
   localparam int AW    = 5;
   localparam int CW    = 6;

   logic                clk = 1'b0;
   logic                res_n;
   logic [NRP*AW-1:0]   rs_addr;
   logic [NRP*XLEN-1:0] rs_data;
   logic [NRP-1:0]      rs_busy;
   logic                wr_en;
   logic [AW-1:0]       wr_addr;
   logic [XLEN-1:0]     wr_data;
   logic                issue_valid;
   logic [AW-1:0]       issue_rd;
   logic                issue_ready;
   logic                flush;
   logic [CW-1:0]       pend_cnt;

   int errors = 0;
   int checks = 0;

   reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP)) dut (
      .clk         (clk),
      .res_n       (res_n),
      .rs_addr     (rs_addr),
      .rs_data     (rs_data),
      .rs_busy     (rs_busy),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .issue_ready (issue_ready),
      .flush       (flush),
      .pend_cnt    (pend_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      rs_addr = {a1, a0};
   endtask

   task automatic idle();
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      issue_valid = 1'b0; issue_rd = '0; flush = 1'b0;
   endtask

   initial begin
      res_n = 1'b0;
      rd(5'd0, 5'd0);
      idle();
      #2;
      check("rst_data", rs_data[31:0], 32'h0);
      check("rst_busy", {30'd0, rs_busy}, 32'h0);
      check("rst_pend", {26'd0, pend_cnt}, 32'h0);
      check("rst_ready", {31'd0, issue_ready}, 32'h1);
      @(posedge clk); #2;
      res_n = 1'b1;

      // ---- issue x5, WAW block, write back ----
      issue_valid = 1'b1; issue_rd = 5'd5; rd(5'd5, 5'd0);
      #1;
      check("iss5_ready", {31'd0, issue_ready}, 32'h1);
      tick();
      check("iss5_busy", {31'd0, rs_busy[0]}, 32'h1);
      check("iss5_pend", {26'd0, pend_cnt}, 32'h1);
      check("iss5_waw_ready", {31'd0, issue_ready}, 32'h0);
      tick();
      check("iss5_pend_hold", {26'd0, pend_cnt}, 32'h1);
      issue_valid = 1'b0;
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
      #1;
`ifdef RF_BYPASS_EN
      check("wr5_busy_same", {31'd0, rs_busy[0]}, 32'h0);
`else
      check("wr5_busy_same", {31'd0, rs_busy[0]}, 32'h1);
`endif
      tick();
      idle();
      #1;
      check("wr5_busy", {31'd0, rs_busy[0]}, 32'h0);
      check("wr5_data", rs_data[31:0], 32'hDEADBEEF);
      check("wr5_pend", {26'd0, pend_cnt}, 32'h0);

      // ---- same-cycle forwarding on x7, port 1 reads x5 ----
      rd(5'd7, 5'd5);
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
      #1;
`ifdef RF_BYPASS_EN
      check("byp7_same", rs_data[31:0], 32'h12345678);
`else
      check("byp7_same", rs_data[31:0], 32'h0);
`endif
      check("p1_x5", rs_data[63:32], 32'hDEADBEEF);
      tick();
      idle();
      #1;
      check("byp7_next", rs_data[31:0], 32'h12345678);

      // ---- issue + write to busy x3 in the same cycle ----
      issue_valid = 1'b1; issue_rd = 5'd3;
      tick();
      idle();
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h00000033;
      issue_valid = 1'b1; issue_rd = 5'd3; rd(5'd0, 5'd3);
      #1;
      check("x3_coll_ready", {31'd0, issue_ready}, 32'h1);
      tick();
      idle();
      #1;
      check("x3_busy", {31'd0, rs_busy[1]}, 32'h1);
      check("x3_data", rs_data[63:32], 32'h00000033);
      check("x3_pend", {26'd0, pend_cnt}, 32'h1);

      // ---- x0 is immutable ----
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
      issue_valid = 1'b1; issue_rd = 5'd0; rd(5'd0, 5'd3);
      #1;
      check("x0_ready", {31'd0, issue_ready}, 32'h1);
      check("x0_data_same", rs_data[31:0], 32'h0);
      tick();
      idle();
      #1;
      check("x0_data", rs_data[31:0], 32'h0);
      check("x0_busy", {31'd0, rs_busy[0]}, 32'h0);
      check("x0_pend", {26'd0, pend_cnt}, 32'h1);

      // ---- flush with x1..x4 pending, concurrent issue x6 and write x2 ----
      for (int r = 1; r <= 4; r++) begin
         if (r != 3) begin
            issue_valid = 1'b1; issue_rd = AW'(r);
            tick();
         end
      end
      idle();
      #1;
      check("pre_flush_pend", {26'd0, pend_cnt}, 32'h4);
      flush = 1'b1;
      issue_valid = 1'b1; issue_rd = 5'd6;
      wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h000000A5;
      tick();
      idle();
      rd(5'd6, 5'd2);
      #1;
      check("flush_pend", {26'd0, pend_cnt}, 32'h0);
      check("flush_busy6", {31'd0, rs_busy[0]}, 32'h0);
      check("flush_busy2", {31'd0, rs_busy[1]}, 32'h0);
      check("flush_data2", rs_data[63:32], 32'h000000A5);
      rd(5'd1, 5'd4);
      #1;
      check("flush_busy1_4", {30'd0, rs_busy}, 32'h0);

      // ---- asynchronous reset mid-run with x5, x9 pending ----
      issue_valid = 1'b1; issue_rd = 5'd5;
      tick();
      issue_rd = 5'd9;
      tick();
      idle();
      rd(5'd5, 5'd9);
      #1;
      check("pre_rst_pend", {26'd0, pend_cnt}, 32'h2);
      check("pre_rst_busy", {30'd0, rs_busy}, 32'h3);
      issue_rd = 5'd5;
      res_n = 1'b0;
      #1;
      check("mrst_data5", rs_data[31:0], 32'h0);
      check("mrst_busy", {30'd0, rs_busy}, 32'h0);
      check("mrst_pend", {26'd0, pend_cnt}, 32'h0);
      check("mrst_ready", {31'd0, issue_ready}, 32'h1);
      @(negedge clk);
      res_n = 1'b1;
      issue_valid = 1'b1; issue_rd = 5'd9;
      tick();
      idle();
      #1;
      check("post_rst_busy9", {31'd0, rs_busy[1]}, 32'h1);
      check("post_rst_pend", {26'd0, pend_cnt}, 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
